// File: rtl/pulse_event_arbiter.sv
// Latches one-cycle event pulses per requester and offers them one at a time
// through a valid/ready port, round-robin from the last granted index.
module pulse_event_arbiter #(
    parameter int WIDTH    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    pulse_in,
    input  logic                evt_ready,
    input  logic                clear_drops,
    output logic                evt_valid,
    output logic [ID_WIDTH-1:0] evt_id,
    output logic [WIDTH-1:0]    pending,
    output logic [7:0]          drop_count,
    output logic                overflow
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                evt_valid_q, evt_valid_d;
    logic [ID_WIDTH-1:0] evt_id_q, evt_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]    pending_q, pending_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                overflow_q, overflow_d;

    logic                hs;
    logic [WIDTH-1:0]    clr_mask;
    logic [WIDTH-1:0]    drop_vec;
    logic                found;
    logic [ID_WIDTH-1:0] sel_id;
    int                  idx;

    always_comb begin
        hs = evt_valid_q && evt_ready;
        clr_mask = '0;
        for (int i = 0; i < WIDTH; i++)
            clr_mask[i] = hs && (evt_id_q == ID_WIDTH'(i));

        // A pulse on the bit being retired re-latches it rather than dropping.
        drop_vec  = pulse_in & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | pulse_in;

        found  = 1'b0;
        sel_id = '0;
        idx    = 0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= WIDTH) idx = idx - WIDTH;
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                sel_id = ID_WIDTH'(idx);
            end
        end

        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = OFFER;
                    evt_valid_d = 1'b1;
                    evt_id_d    = sel_id;
                end
            end
            default: begin
                if (hs) begin
                    state_d     = IDLE;
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_id_q == ID_WIDTH'(WIDTH - 1)) ? '0
                                : ID_WIDTH'(evt_id_q + 1'b1);
                end
            end
        endcase

        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (|drop_vec) begin
            overflow_d   = 1'b1;
            drop_count_d = clear_drops ? 8'd1
                         : (drop_count_q == 8'hff) ? 8'hff : drop_count_q + 8'd1;
        end else if (clear_drops) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            rr_ptr_q     <= '0;
            pending_q    <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            rr_ptr_q     <= rr_ptr_d;
            pending_q    <= pending_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign pending    = pending_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed stimulus with an id scoreboard; a negedge monitor pops expected ids on
// each handshake and checks offer stability under back-pressure.
module tb_pulse_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pulse_in = '0;
    logic       evt_ready = 1'b0;
    logic       clear_drops = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic [7:0] drop_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    pulse_event_arbiter #(.WIDTH(4), .ID_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .evt_ready(evt_ready),
        .clear_drops(clear_drops), .evt_valid(evt_valid), .evt_id(evt_id),
        .pending(pending), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        pulse_in    = '0;
        evt_ready   = 1'b0;
        clear_drops = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: scoreboard pop on handshake, and hold stability under back-pressure.
    logic       prev_hold = 1'b0;
    logic [1:0] prev_id = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", int'(evt_valid), 1);
                check("hold_id", int'(evt_id), int'(prev_id));
            end
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got id %0d expected no event", evt_id);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    if (evt_id != e) begin
                        errors++;
                        $display("FAIL event_id: got %0d expected %0d", evt_id, e);
                    end
                end
            end
            prev_hold = evt_valid && !evt_ready;
            prev_id   = evt_id;
        end
    end

    initial begin
        // Reset state
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_id", int'(evt_id), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_drops", int'(drop_count), 0);
        check("rst_ovf", int'(overflow), 0);
        tick();
        rst = 1'b0;

        // Single pulse
        evt_ready = 1'b1;
        pulse_in = 4'b0010; exp_q.push_back(2'd1);
        tick();
        pulse_in = '0;
        repeat (4) tick();
        check("single_drained", exp_q.size(), 0);
        check("single_pending", int'(pending), 0);

        // Round-robin burst from rr_ptr=0, at one event per two cycles
        do_reset();
        evt_ready = 1'b1;
        pulse_in = 4'b1111;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        tick();
        pulse_in = '0;
        repeat (8) tick();
        check("rr_burst_drained", exp_q.size(), 0);
        check("rr_burst_pending", int'(pending), 0);

        // rr_ptr=2 after granting id 1, then 0101 -> 2 then 0
        pulse_in = 4'b0010; exp_q.push_back(2'd1);
        tick();
        pulse_in = '0;
        repeat (4) tick();
        pulse_in = 4'b0101; exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        tick();
        pulse_in = '0;
        repeat (6) tick();
        check("rr_wrap_drained", exp_q.size(), 0);

        // Back-pressure: held offer for 5 cycles, then one handshake
        do_reset();
        pulse_in = 4'b0001; exp_q.push_back(2'd0);
        tick();
        pulse_in = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", int'(evt_valid), 1);
            check("bp_id", int'(evt_id), 0);
            tick();
        end
        evt_ready = 1'b1;
        tick();
        repeat (4) begin
            check("bp_no_more", int'(evt_valid), 0);
            tick();
        end
        check("bp_drained", exp_q.size(), 0);

        // Drops during hold: saturation, clear with coincident drop, plain clear
        do_reset();
        pulse_in = 4'b0001; exp_q.push_back(2'd0);
        tick();
        repeat (300) tick();
        pulse_in = '0;
        check("sat_count", int'(drop_count), 255);
        check("sat_ovf", int'(overflow), 1);
        pulse_in = 4'b0001; clear_drops = 1'b1;
        tick();
        pulse_in = '0;
        check("clr_drop_prio_cnt", int'(drop_count), 1);
        check("clr_drop_prio_ovf", int'(overflow), 1);
        tick();
        clear_drops = 1'b0;
        check("clr_count", int'(drop_count), 0);
        check("clr_ovf", int'(overflow), 0);
        evt_ready = 1'b1;
        repeat (4) tick();
        check("drop_drained", exp_q.size(), 0);
        check("drop_pending", int'(pending), 0);

        // Pulse coincident with handshake of the same id re-latches it
        do_reset();
        pulse_in = 4'b0001; exp_q.push_back(2'd0);
        tick();
        pulse_in = '0;
        tick();
        evt_ready = 1'b1; pulse_in = 4'b0001; exp_q.push_back(2'd0);
        tick();
        pulse_in = '0;
        check("coinc_pending", int'(pending), 1);
        check("coinc_drops", int'(drop_count), 0);
        repeat (4) tick();
        check("coinc_drained", exp_q.size(), 0);
        check("coinc_pending_end", int'(pending), 0);

        // Reset mid-offer with pending=0110
        do_reset();
        pulse_in = 4'b0110;
        tick();
        pulse_in = '0;
        tick();
        check("pre_rst_valid", int'(evt_valid), 1);
        check("pre_rst_pending", int'(pending), 6);
        #1 rst = 1'b1;
        #1;
        check("async_valid", int'(evt_valid), 0);
        check("async_id", int'(evt_id), 0);
        check("async_pending", int'(pending), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        evt_ready = 1'b1;
        repeat (5) begin
            tick();
            check("post_rst_quiet", int'(evt_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
